// File: rtl/microprocessor_pkg.sv
// Shared definitions for the microprocessor and its bytecode loader front end.
//   DEPTH / ADDR_W  : program memory geometry (ADDR_W = $clog2(DEPTH))
//   TERM_BYTE       : end-of-program marker the core halts on
//   mem_t           : packed program memory image, as consumed by the core
//   loader_state_e  : bytecode loader control states
package microprocessor_pkg;

    localparam int unsigned DEPTH     = 1024;
    localparam int unsigned ADDR_W    = $clog2(DEPTH);
    localparam logic [7:0]  TERM_BYTE = 8'hFF;

    typedef logic [DEPTH-1:0][7:0] mem_t;

    typedef enum logic [1:0] {
        LOAD,
        TERM,
        RUN,
        ERR
    } loader_state_e;

endpackage

// File: rtl/bytecode_loader.sv
// Bytecode loader: upstream stage of the microprocessor.
// Accepts a byte stream over valid/ready, stores it into a DEPTH x 8 flop
// memory, appends the terminator byte and then raises enable for the core.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : in_data / in_last valid
//   in_data      : bytecode byte
//   in_last      : marks the final program byte
//   in_ready     : loader accepts a byte this cycle
//   reload       : one-cycle pulse, discard program and restart loading
//   memory       : full program memory image, packed [DEPTH-1:0][7:0]
//   enable       : program loaded and terminated, core may run
//   load_count   : program length in bytes, terminator excluded
//   overflow     : sticky, stream did not fit in DEPTH-1 bytes
module bytecode_loader #(
    parameter int unsigned DEPTH  = microprocessor_pkg::DEPTH,
    parameter int unsigned ADDR_W = microprocessor_pkg::ADDR_W,
    parameter logic [7:0]  TERM   = microprocessor_pkg::TERM_BYTE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   reload,
    output logic [DEPTH-1:0][7:0]  memory,
    output logic                   enable,
    output logic [ADDR_W:0]        load_count,
    output logic                   overflow
);

    // Last slot is reserved for the terminator, so data may only go below it.
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

    microprocessor_pkg::loader_state_e state_q, state_d;

    logic [ADDR_W-1:0]       wr_ptr;
    logic [DEPTH-1:0][7:0]   mem_q;
    logic                    enable_q;
    logic                    overflow_q;
    logic [ADDR_W:0]         load_count_q;

    logic                    ready_c;
    logic                    accept;
    logic                    term_wr;
    logic                    ovf_hit;

    // ---------------------------------------------------------------
    // Next-state and strobes
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        accept  = 1'b0;
        term_wr = 1'b0;
        ovf_hit = 1'b0;

        case (state_q)
            microprocessor_pkg::LOAD: begin
                ready_c = (wr_ptr != LAST_SLOT);
                if (in_valid && ready_c) begin
                    accept = 1'b1;
                    if (in_last) begin
                        state_d = microprocessor_pkg::TERM;
                    end
                end else if (in_valid) begin
                    // Pointer parked on the terminator slot: stream too long.
                    ovf_hit = 1'b1;
                    state_d = microprocessor_pkg::ERR;
                end
            end
            microprocessor_pkg::TERM: begin
                term_wr = 1'b1;
                state_d = microprocessor_pkg::RUN;
            end
            microprocessor_pkg::RUN: begin
                state_d = microprocessor_pkg::RUN;
            end
            microprocessor_pkg::ERR: begin
                state_d = microprocessor_pkg::ERR;
            end
        endcase

        // reload wins over everything, including a same-cycle handshake.
        if (reload) begin
            state_d = microprocessor_pkg::LOAD;
            accept  = 1'b0;
            term_wr = 1'b0;
            ovf_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= microprocessor_pkg::LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Pointer, status and length registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            enable_q     <= 1'b0;
            overflow_q   <= 1'b0;
            load_count_q <= '0;
        end else if (reload) begin
            wr_ptr       <= '0;
            enable_q     <= 1'b0;
            overflow_q   <= 1'b0;
            load_count_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ovf_hit) begin
                overflow_q <= 1'b1;
            end
            if (term_wr) begin
                load_count_q <= {1'b0, wr_ptr};
                enable_q     <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Program memory: not reset; only valid once enable is high.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr] <= in_data;
        end else if (term_wr) begin
            mem_q[wr_ptr] <= TERM;
        end
    end

    assign in_ready   = ready_c & rst_n;
    assign memory     = mem_q;
    assign enable     = enable_q;
    assign overflow   = overflow_q;
    assign load_count = load_count_q;

endmodule

// File: doc/bytecode_loader.md
Name: bytecode_loader

Overview:
- Upstream stage of the microprocessor.
- Accepts a bytecode stream over a valid/ready handshake and writes it into a DEPTH x 8 program memory.
- Appends the 0xFF end-of-program terminator, then raises enable to start the core.
- Exposes the whole memory as a packed array in the same shape the microprocessor's memory input consumes.

Parameters:
- DEPTH, 1024, program memory entries.
- ADDR_W, 10, write-pointer width; equals $clog2(DEPTH).
- TERM, 8'hFF, terminator byte written after the last program byte.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_last are valid.
- in_data  input  8  bytecode byte.
- in_last  input  1  qualifies in_data as the final program byte.
- in_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  single-cycle pulse: discard the program and start a new load.
- memory  output  DEPTH x 8 (packed [DEPTH-1:0][7:0])  program memory contents, fed straight to the microprocessor.
- enable  output  1  program loaded and terminated; core may run.
- load_count  output  ADDR_W+1  number of program bytes, excluding the terminator.
- overflow  output  1  sticky error: stream exceeded DEPTH-1 bytes.

Behaviour:
- Reset (async assert, sync deassert):
  - state=LOAD, wr_ptr=0.
  - enable=0, overflow=0, load_count=0.
  - in_ready=1 once rst_n is high.
  - Memory contents are not reset. The consumer must not read memory while enable=0.
- States: LOAD, TERM, RUN, ERR.
- LOAD:
  - in_ready = (wr_ptr < DEPTH-1).
  - On in_valid&in_ready: mem[wr_ptr]<=in_data and wr_ptr<=wr_ptr+1.
  - If in_last is also high, go to TERM.
  - If wr_ptr==DEPTH-1 and in_valid=1: the byte is not accepted, overflow<=1, go to ERR. No slot is left for the terminator.
  - A byte value of 0xFF is stored unfiltered. The loader gives it no meaning; the core halts on it.
- TERM (exactly one cycle):
  - in_ready=0.
  - mem[wr_ptr]<=TERM, load_count<=wr_ptr, enable<=1, go to RUN.
- Timing: enable is first seen high 2 cycles after the handshake cycle of the in_last byte.
- RUN:
  - enable=1 and in_ready=0.
  - Memory is frozen; in_valid is ignored.
- ERR:
  - enable=0, in_ready=0, overflow=1.
  - Leaves only on reload or reset.
- reload, in any state:
  - Next cycle: state=LOAD, wr_ptr=0, enable=0, overflow=0, load_count=0.
  - reload has priority over a simultaneous handshake; that byte is dropped.
  - Old memory contents remain until overwritten.
- load_count holds its value through RUN. It is cleared only by reset or reload.
- Minimum program is 1 byte (in_last on the first byte), giving load_count=1 and mem[1]=TERM.
- Maximum program is DEPTH-1 bytes: in_last at index DEPTH-2, terminator at DEPTH-1.
- An asynchronous reset mid-load or mid-run returns immediately to reset values. enable drops combinationally with rst_n.

Decomposition:
- Shared package microprocessor_pkg holds:
  - DEPTH and ADDR_W constants.
  - TERM_BYTE = 8'hFF.
  - A mem_t typedef (logic [DEPTH-1:0][7:0]) used by both the loader and the microprocessor.
  - The state enum loader_state_e {LOAD, TERM, RUN, ERR}.
- Single module; no sub-module is needed. The memory is a flop array indexed by wr_ptr.

Test Plan:
- Stream 0x01,0x02,0x03 with in_last on 0x03, valid every cycle:
  - mem[0..3]=01,02,03,FF.
  - load_count=3.
  - enable rises 2 cycles after the 0x03 handshake; in_ready=0 afterwards.
- Same stream with in_valid toggling 1/0 and stalls of 0–3 cycles: identical memory and load_count. No byte is duplicated or lost.
- Single byte 0xA5 with in_last: mem[0]=A5, mem[1]=FF, load_count=1, enable=1.
- Boundary cases:
  - 1023 bytes (value i[7:0]) with in_last on the 1023rd: mem[1023]=FF, load_count=1023, overflow=0.
  - 1024 bytes without in_last: in_ready=0 at wr_ptr=1023; the next in_valid sets overflow=1, enable stays 0.
- After the overflow case, pulse reload, then stream 0x10 with in_last: overflow=0, mem[0]=10, mem[1]=FF, enable=1.
- Reset and reload mid-operation:
  - Deassert rst_n mid-load after 5 bytes: enable/overflow/load_count go to 0 immediately. Reload 2 bytes gives load_count=2.
  - Assert reload during RUN: enable drops the next cycle and in_ready returns to 1.
